// File: rtl/rand_pkg.sv
// rand_pkg: shared state encoding, default retry sizing and rejection mask helper.
package rand_pkg;

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    localparam int DEF_TRIES = 16;
    localparam int TRY_W = $clog2(DEF_TRIES + 1);

    // Smallest 2^k-1 covering lim-1, found by smearing the top set bit downward.
    function automatic logic [31:0] range_mask(input logic [31:0] lim);
        logic [31:0] m;
        m = (lim <= 32'd1) ? 32'd0 : lim - 32'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/rand_accept.sv
// rand_accept: in-range test on a masked candidate and its folded fallback value.
module rand_accept #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] lim_q,
    output logic             accept,
    output logic [WIDTH-1:0] c_minus_lim
);

    assign accept      = c < lim_q;
    assign c_minus_lim = c - lim_q;

endmodule

// File: rtl/rand_range.sv
// rand_range: unbiased draw in [0, limit) from an LFSR byte via masked rejection sampling.
module rand_range
    import rand_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_TRIES = DEF_TRIES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rnd_in,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] value,
    output logic             fallback,
    output logic [15:0]      draw_count
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    state_t           state;
    logic [TW-1:0]    tries;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] c_minus_lim;
    logic             accept;

    assign c         = rnd_in & mask_q;
    assign busy      = state != IDLE;
    assign out_valid = state == HOLD;

    rand_accept #(.WIDTH(WIDTH)) u_accept (
        .c          (c),
        .lim_q      (lim_q),
        .accept     (accept),
        .c_minus_lim(c_minus_lim)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tries      <= '0;
            lim_q      <= '0;
            mask_q     <= '0;
            value      <= '0;
            fallback   <= 1'b0;
            draw_count <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    lim_q    <= limit;
                    mask_q   <= WIDTH'(range_mask(32'(limit)));
                    tries    <= '0;
                    value    <= '0;
                    fallback <= 1'b0;
                    state    <= (limit <= WIDTH'(1)) ? HOLD : DRAW;
                end
                DRAW: if (accept) begin
                    value    <= c;
                    fallback <= 1'b0;
                    state    <= HOLD;
                end else if (tries == TW'(MAX_TRIES - 1)) begin
                    // mask_q < 2*lim_q, so the folded value is still in range
                    value    <= c_minus_lim;
                    fallback <= 1'b1;
                    state    <= HOLD;
                end else begin
                    tries <= tries + TW'(1);
                end
                HOLD: if (out_ready) begin
                    draw_count <= draw_count + 16'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_range.sv
// tb_rand_range: directed vector table plus hand sequences for rand_range.
module tb_rand_range;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rnd_in = 8'h00;
    logic       req = 1'b0;
    logic [7:0] limit = 8'h00;
    logic       busy;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] value;
    logic       fallback;
    logic [15:0] draw_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    typedef struct {
        logic [7:0] lim;
        logic [7:0] rnd;
        logic [7:0] val;
        logic       fb;
        int         lat;
    } vec_t;

    vec_t vt[11];

    rand_range dut (
        .clk       (clk),
        .reset     (reset),
        .rnd_in    (rnd_in),
        .req       (req),
        .limit     (limit),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value     (value),
        .fallback  (fallback),
        .draw_count(draw_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic run_draw(input logic [7:0] lim, input logic [7:0] rnd,
                            input logic [7:0] ev, input logic efb, input int elat);
        int lat;
        @(negedge clk);
        limit = lim;
        rnd_in = rnd;
        req = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            req = 1'b0;
        end while (!out_valid && lat < 40);
        chk("latency", lat, elat);
        chk("value", int'(value), int'(ev));
        chk("fallback", int'(fallback), int'(efb));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("draw_count", int'(draw_count), int'(exp_cnt));
        chk("valid_clear", int'(out_valid), 0);
    endtask

    initial begin
        vt[0]  = '{8'd1,   8'h5A, 8'd0,   1'b0, 1};
        vt[1]  = '{8'd0,   8'hFF, 8'd0,   1'b0, 1};
        vt[2]  = '{8'd6,   8'h0B, 8'd3,   1'b0, 2};
        vt[3]  = '{8'd9,   8'h0F, 8'd6,   1'b1, 17};
        vt[4]  = '{8'd255, 8'hFE, 8'd254, 1'b0, 2};
        vt[5]  = '{8'd255, 8'hFF, 8'd0,   1'b1, 17};
        vt[6]  = '{8'd2,   8'h03, 8'd1,   1'b0, 2};
        vt[7]  = '{8'd8,   8'h0F, 8'd7,   1'b0, 2};
        vt[8]  = '{8'd128, 8'hC5, 8'd69,  1'b0, 2};
        vt[9]  = '{8'd129, 8'hFF, 8'd126, 1'b1, 17};
        vt[10] = '{8'd100, 8'h64, 8'd0,   1'b1, 17};

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_value", int'(value), 0);
        chk("rst_fallback", int'(fallback), 0);
        chk("rst_count", int'(draw_count), 0);
        @(negedge clk);
        reset = 1'b1;

        // limit 1 resolves in one cycle, then the result is held without out_ready
        @(negedge clk);
        limit = 8'd1;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("lim1_valid", int'(out_valid), 1);
        chk("lim1_value", int'(value), 0);
        chk("lim1_fallback", int'(fallback), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_value", int'(value), 0);
            chk("hold_busy", int'(busy), 1);
            chk("hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("lim1_count", int'(draw_count), int'(exp_cnt));

        for (int i = 0; i < 11; i++)
            run_draw(vt[i].lim, vt[i].rnd, vt[i].val, vt[i].fb, vt[i].lat);

        // rejection then accept, with req kept high through DRAW and HOLD
        @(negedge clk);
        limit = 8'd6;
        rnd_in = 8'h00;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        limit = 8'd1;
        rnd_in = 8'h07;
        @(posedge clk);
        @(negedge clk);
        rnd_in = 8'h0E;
        chk("rej_busy1", int'(busy), 1);
        chk("rej_valid1", int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        rnd_in = 8'h02;
        chk("rej_valid2", int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rej_valid3", int'(out_valid), 1);
        chk("rej_value", int'(value), 2);
        chk("rej_fallback", int'(fallback), 0);
        @(negedge clk);
        chk("req_in_hold_value", int'(value), 2);
        chk("req_in_hold_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("same_cycle_req_busy", int'(busy), 0);
        chk("same_cycle_count", int'(draw_count), int'(exp_cnt));
        @(negedge clk);
        req = 1'b0;
        chk("next_req_busy", int'(busy), 1);
        chk("next_req_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("next_req_count", int'(draw_count), int'(exp_cnt));

        // draw_count wrap from 0xFFFF
        @(negedge clk);
        force dut.draw_count = 16'hFFFF;
        @(negedge clk);
        release dut.draw_count;
        exp_cnt = 16'hFFFF;
        run_draw(8'd6, 8'h0B, 8'd3, 1'b0, 2);

        // asynchronous reset during the second retry discards the draw
        @(negedge clk);
        limit = 8'd6;
        rnd_in = 8'h07;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_count", int'(draw_count), int'(exp_cnt));
        @(negedge clk);
        reset = 1'b1;
        run_draw(8'd255, 8'hFE, 8'd254, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
